// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
package dmem_access_ctrl_pkg;

    localparam int DMEM_ADDR_W = 64;
    localparam int DMEM_DATA_W = 64;
    localparam int DMEM_MASK_W = DMEM_DATA_W / 8;

    typedef logic [DMEM_ADDR_W-1:0] addr_t;
    typedef logic [DMEM_DATA_W-1:0] data_t;
    typedef logic [DMEM_MASK_W-1:0] mask_t;

    typedef enum logic [2:0] {
        MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW
    } mem_op_enum;

    typedef enum logic [1:0] {
        IDLE, REQ, WAIT, DONE
    } dmem_state_enum;

    // Move LSB-justified store data onto its byte lanes; bytes past the word are dropped.
    function automatic data_t align_wdata(input data_t d, input logic [2:0] off);
        return d << {off, 3'b000};
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response bus between the access controller and data memory.
interface dmem_access_ctrl_if;
    import dmem_access_ctrl_pkg::*;

    logic  dmem_req_valid;
    logic  dmem_req_ready;
    addr_t dmem_req_addr;
    logic  dmem_req_we;
    data_t dmem_req_wdata;
    mask_t dmem_req_wmask;
    logic  dmem_resp_valid;
    data_t dmem_resp_data;

    modport master (
        output dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wmask,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr, dmem_req_we, dmem_req_wdata, dmem_req_wmask,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

endinterface

// File: rtl/dmem_access_ctrl_load_data_ext.sv
// Load result formatter: selects the addressed bytes and sign/zero-extends to 64 bits.
// Latency: combinational.
// Backpressure: none.
module dmem_access_ctrl_load_data_ext
    import dmem_access_ctrl_pkg::*;
(
    input  data_t      raw,
    input  logic [2:0] offset,
    input  mem_op_enum op,
    output data_t      ext
);

    data_t shifted;

    always_comb begin
        shifted = raw >> {offset, 3'b000};
        ext     = shifted;
        case (op)
            MEM_B:   ext = {{56{shifted[7]}},  shifted[7:0]};
            MEM_H:   ext = {{48{shifted[15]}}, shifted[15:0]};
            MEM_W:   ext = {{32{shifted[31]}}, shifted[31:0]};
            MEM_UB:  ext = {56'd0, shifted[7:0]};
            MEM_UH:  ext = {48'd0, shifted[15:0]};
            MEM_UW:  ext = {32'd0, shifted[31:0]};
            default: ext = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: latches one load/store, runs the dmem handshake, stalls the pipe.
// Latency: accept to done_o is 3 cycles minimum (REQ, WAIT, DONE); grows with ready/response delay.
// Backpressure: request held stable while dmem_req_ready is low; stall_o holds the pipeline throughout.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  mem_op_enum        mem_op,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  mask_t             mem_wmask,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    dmem_access_ctrl_if.master dmem
);

    dmem_state_enum    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        off_q, off_d;
    mem_op_enum        op_q, op_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    mask_t             wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              stall_c;
    logic              req_present;
    data_t             ext_data;

    assign req_present = (mem_we | mem_re) && (mem_op != MEM_NO);

    dmem_access_ctrl_load_data_ext u_load_data_ext (
        .raw    (dmem.dmem_resp_data),
        .offset (off_q),
        .op     (op_q),
        .ext    (ext_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        op_d    = op_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        stall_c = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_c = req_present;
                if (req_present) begin
                    state_d = REQ;
                    addr_d  = {mem_addr[ADDR_W-1:3], 3'b000};
                    off_d   = mem_addr[2:0];
                    op_d    = mem_op;
                    // A simultaneous load request is dropped: the store wins.
                    we_d    = mem_we;
                    wdata_d = mem_we ? align_wdata(mem_wdata, mem_addr[2:0]) : '0;
                    wmask_d = mem_we ? mem_wmask : '0;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (dmem.dmem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                stall_c = 1'b1;
                if (dmem.dmem_resp_valid) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = ext_data;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            op_q    <= MEM_NO;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            op_q    <= op_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall_o             = rstn && stall_c;
    assign rdata_o             = rdata_q;
    assign dmem.dmem_req_valid = (state_q == REQ);
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_wdata = wdata_q;
    assign dmem.dmem_req_wmask = wmask_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed loads/stores, backpressure and mid-access reset.
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    mem_op_enum  mem_op = MEM_NO;
    logic        mem_we = 1'b0;
    logic        mem_re = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wmask = '0;
    logic        stall_o;
    logic        done_o;
    logic [63:0] rdata_o;

    dmem_access_ctrl_if dif();

    dmem_access_ctrl u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_op    (mem_op),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .rdata_o   (rdata_o),
        .dmem      (dif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_exp_t;

    typedef struct {
        string       name;
        logic [63:0] rdata;
    } done_exp_t;

    req_exp_t    req_q[$];
    done_exp_t   done_q[$];
    logic [63:0] last_rdata = '0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or a completion.
    always @(negedge clk) begin
        if (rstn) begin
            if (dif.dmem_req_valid && dif.dmem_req_ready) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req actual=addr_%h required=none", dif.dmem_req_addr);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    check64({r.name, "_req_addr"}, dif.dmem_req_addr, r.addr);
                    check64({r.name, "_req_we"}, 64'(dif.dmem_req_we), 64'(r.we));
                    check64({r.name, "_req_wmask"}, 64'(dif.dmem_req_wmask), 64'(r.wmask));
                    if (r.we) check64({r.name, "_req_wdata"}, dif.dmem_req_wdata, r.wdata);
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    check64({d.name, "_rdata"}, rdata_o, d.rdata);
                end
            end
        end
    end

    task automatic access(input string nm, input mem_op_enum op, input logic we, input logic re,
                          input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wmask,
                          input int rdy_dly, input int rsp_dly, input int spur,
                          input logic [63:0] rsp_data, input logic [63:0] exp_wdata,
                          input logic [63:0] exp_rdata);
        req_exp_t  r;
        done_exp_t d;
        logic [63:0] exp_addr;
        exp_addr = {addr[63:3], 3'b000};
        r.name = nm; r.addr = exp_addr; r.we = we; r.wdata = exp_wdata;
        r.wmask = we ? wmask : 8'h00;
        req_q.push_back(r);
        d.name = nm;
        d.rdata = we ? last_rdata : exp_rdata;
        last_rdata = d.rdata;
        done_q.push_back(d);

        mem_op = op; mem_we = we; mem_re = re;
        mem_addr = addr; mem_wdata = wdata; mem_wmask = wmask;
        #1;
        check64({nm, "_stall_idle"}, 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        // Junk on the pipeline side must not disturb the latched request.
        mem_op = MEM_NO; mem_we = 1'b0; mem_re = 1'b0;
        mem_addr = ~addr; mem_wdata = ~wdata; mem_wmask = ~wmask;
        for (int i = 0; i < rdy_dly; i++) begin
            check64({nm, "_bp_valid"}, 64'(dif.dmem_req_valid), 64'd1);
            check64({nm, "_bp_stall"}, 64'(stall_o), 64'd1);
            check64({nm, "_bp_addr"}, dif.dmem_req_addr, exp_addr);
            if (we) check64({nm, "_bp_wdata"}, dif.dmem_req_wdata, exp_wdata);
            dif.dmem_resp_valid = (i == spur);
            dif.dmem_resp_data  = 64'hDEAD_DEAD_DEAD_DEAD;
            @(posedge clk); #1;
        end
        dif.dmem_resp_valid = 1'b0;
        check64({nm, "_req_valid"}, 64'(dif.dmem_req_valid), 64'd1);
        check64({nm, "_req_done"}, 64'(done_o), 64'd0);
        dif.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dif.dmem_req_ready = 1'b0;
        for (int i = 0; i < rsp_dly; i++) begin
            check64({nm, "_wait_stall"}, 64'(stall_o), 64'd1);
            @(posedge clk); #1;
        end
        check64({nm, "_wait_valid"}, 64'(dif.dmem_req_valid), 64'd0);
        check64({nm, "_wait_stall"}, 64'(stall_o), 64'd1);
        dif.dmem_resp_valid = 1'b1;
        dif.dmem_resp_data  = rsp_data;
        @(posedge clk); #1;
        dif.dmem_resp_valid = 1'b0;
        dif.dmem_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        check64({nm, "_done"}, 64'(done_o), 64'd1);
        check64({nm, "_done_stall"}, 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        check64({nm, "_after_done"}, 64'(done_o), 64'd0);
        check64({nm, "_after_valid"}, 64'(dif.dmem_req_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.dmem_req_ready  = 1'b0;
        dif.dmem_resp_valid = 1'b0;
        dif.dmem_resp_data  = '0;
        // Request present during reset must not raise stall_o.
        mem_op = MEM_D; mem_we = 1'b1; mem_addr = 64'h1008; mem_wdata = 64'h55; mem_wmask = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check64("rst_stall", 64'(stall_o), 64'd0);
        check64("rst_valid", 64'(dif.dmem_req_valid), 64'd0);
        check64("rst_done", 64'(done_o), 64'd0);
        check64("rst_rdata", rdata_o, 64'd0);
        check64("rst_addr", dif.dmem_req_addr, 64'd0);
        check64("rst_we", 64'(dif.dmem_req_we), 64'd0);
        check64("rst_wdata", dif.dmem_req_wdata, 64'd0);
        check64("rst_wmask", 64'(dif.dmem_req_wmask), 64'd0);
        mem_op = MEM_NO; mem_we = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;

        access("sd",  MEM_D,  1, 0, 64'h1000, 64'h1122334455667788, 8'hFF, 0, 0, -1,
               64'h0, 64'h1122334455667788, 64'h0);
        access("sb",  MEM_B,  1, 0, 64'h1005, 64'h00000000000000AB, 8'h20, 0, 0, -1,
               64'h0, 64'h0000AB0000000000, 64'h0);
        access("lb",  MEM_B,  0, 1, 64'h2003, 64'h0, 8'h08, 0, 0, -1,
               64'h0000000080000000, 64'h0, 64'hFFFFFFFFFFFFFF80);
        access("lbu", MEM_UB, 0, 1, 64'h2003, 64'h0, 8'h08, 0, 0, -1,
               64'h0000000080000000, 64'h0, 64'h0000000000000080);
        access("lw",  MEM_W,  0, 1, 64'h2004, 64'h0, 8'h00, 0, 2, -1,
               64'h8000000100000000, 64'h0, 64'hFFFFFFFF80000001);
        access("lwu", MEM_UW, 0, 1, 64'h2004, 64'h0, 8'h00, 1, 0, -1,
               64'h8000000100000000, 64'h0, 64'h0000000080000001);
        access("lh",  MEM_H,  0, 1, 64'h2006, 64'h0, 8'h00, 0, 0, -1,
               64'hFFFE123456789ABC, 64'h0, 64'hFFFFFFFFFFFFFFFE);
        access("lhu", MEM_UH, 0, 1, 64'h2006, 64'h0, 8'h00, 0, 0, -1,
               64'hFFFE123456789ABC, 64'h0, 64'h000000000000FFFE);
        access("ld",  MEM_D,  0, 1, 64'h2000, 64'h0, 8'h00, 0, 0, -1,
               64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF);
        access("bp",  MEM_H,  1, 0, 64'h1002, 64'h0000000000001234, 8'h0C, 4, 0, 1,
               64'h0, 64'h0000000012340000, 64'h0);
        access("wr",  MEM_UW, 1, 1, 64'h3004, 64'h00000000DEADBEEF, 8'hF0, 0, 0, -1,
               64'h0, 64'hDEADBEEF00000000, 64'h0);

        // MEM_NO with a store strobe is not a request.
        mem_op = MEM_NO; mem_we = 1'b1; mem_addr = 64'h5000;
        #1;
        check64("nop_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        check64("nop_valid", 64'(dif.dmem_req_valid), 64'd0);
        mem_we = 1'b0;

        // Reset while waiting for a load response abandons it.
        begin
            req_exp_t r;
            r.name = "rst_ld"; r.addr = 64'h4008; r.we = 1'b0; r.wdata = '0; r.wmask = 8'h00;
            req_q.push_back(r);
        end
        mem_op = MEM_D; mem_re = 1'b1; mem_addr = 64'h4008;
        @(posedge clk); #1;
        mem_op = MEM_NO; mem_re = 1'b0;
        dif.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dif.dmem_req_ready = 1'b0;
        check64("rst_wait_stall", 64'(stall_o), 64'd1);
        rstn = 1'b0;
        #1;
        check64("rst_async_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        check64("rst_mid_valid", 64'(dif.dmem_req_valid), 64'd0);
        check64("rst_mid_stall", 64'(stall_o), 64'd0);
        check64("rst_mid_rdata", rdata_o, 64'd0);
        dif.dmem_resp_valid = 1'b1;
        dif.dmem_resp_data  = 64'h7777777777777777;
        @(posedge clk); #1;
        dif.dmem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check64("rst_late_done", 64'(done_o), 64'd0);
            @(posedge clk); #1;
        end
        check64("rst_late_rdata", rdata_o, 64'd0);

        check64("req_q_empty", 64'(req_q.size()), 64'd0);
        check64("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Data-memory access controller in the MEM stage. It sits directly downstream of MaskGen and consumes its byte write mask.
- Latches one load/store request from the pipeline, aligns store data to the 8-byte memory word, and drives the dmem request/response handshake.
- Stalls the pipeline while the access is outstanding.
- For loads, extracts the addressed bytes and sign- or zero-extends them to 64 bits.

Parameters:
- ADDR_W, 64, address width (matches addr_t).
- DATA_W, 64, data width; fixed at 64 with an 8-bit mask.

Ports:
- clk  in  1  core clock
- rstn  in  1  synchronous active-low reset
- mem_op  in  mem_op_enum  access size/sign (MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW)
- mem_we  in  1  store request
- mem_re  in  1  load request
- mem_addr  in  64  byte address
- mem_wdata  in  64  store data, LSB-justified
- mem_wmask  in  8  byte mask from MaskGen, already shifted by addr[2:0]
- stall_o  out  1  hold the pipeline
- done_o  out  1  one-cycle pulse when the access completes
- rdata_o  out  64  extended load result; valid while done_o=1, held afterwards
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts the request
- dmem_req_addr  out  64  {mem_addr[63:3],3'b0}
- dmem_req_we  out  1  1 = store
- dmem_req_wdata  out  64  mem_wdata << (8*addr[2:0])
- dmem_req_wmask  out  8  latched mem_wmask; 0 for loads
- dmem_resp_valid  in  1  response/ack valid
- dmem_resp_data  in  64  read data (don't-care for stores)

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE; all request registers, rdata_o, done_o and dmem_req_valid are 0.
  - stall_o is forced to 0 while rstn=0.
  - Reset mid-access abandons the transaction; any late dmem_resp_valid is ignored.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Request present when (mem_we|mem_re) && mem_op!=MEM_NO.
  - stall_o = request present (combinational).
  - On a request, capture addr, offset, op, we, aligned wdata and mask (0 if load), then go to REQ.
  - mem_we and mem_re both high: treat as a store; mem_re is ignored.
- REQ:
  - dmem_req_valid=1; addr, we, wdata and wmask stay stable until the handshake.
  - On dmem_req_ready=1, go to WAIT and drop valid next cycle.
  - Pipeline inputs are ignored while not in IDLE.
- WAIT:
  - On dmem_resp_valid=1, go to DONE.
  - For loads, register rdata_o = extend(dmem_resp_data >> (8*offset), op).
  - Stores leave rdata_o unchanged.
  - dmem_resp_valid outside WAIT is ignored.
- DONE:
  - done_o=1 and stall_o=0 for exactly one cycle; next state is IDLE.
  - The pipeline advances on this cycle; a new request is sampled in IDLE on the following cycle.
- stall_o=1 in REQ and WAIT, 0 in DONE.
- Minimum latency: accept to done_o is 3 cycles (ready in the first REQ cycle, response in the first WAIT cycle).
- Extension rules:
  - B: sign-extend bits [7:0]; H: sign-extend [15:0]; W: sign-extend [31:0]; D: pass through.
  - UB/UH/UW: zero-extend the same widths.
  - Stores ignore signedness; U* stores behave like B/H/W.
- Misaligned access crossing the 8-byte boundary is unsupported. Bytes shifted out of the word are dropped, with no exception and no split access.

Decomposition:
- CorePack additions:
  - dmem_state_enum {IDLE, REQ, WAIT, DONE}.
  - data_t (64-bit).
  - Reuse the existing addr_t, mask_t and mem_op_enum.
- One combinational sub-module, load_data_ext: inputs raw 64-bit data, offset[2:0] and mem_op; output the extended 64-bit result.

Test Plan:
- SD: mem_we, MEM_D, addr 0x1000, wdata 0x1122334455667788, mask 0xFF; ready and resp each after 1 cycle -> req addr 0x1000, wdata unchanged, wmask 0xFF, stall_o for 2 cycles, done_o pulse at cycle 3.
- SB at addr 0x1005, wdata 0xAB, mask 0x20 -> req addr 0x1000, wdata 0x0000AB0000000000, wmask 0x20.
- LB at addr 0x2003, resp 0x00000000_80000000 -> rdata_o 0xFFFFFFFFFFFFFF80. Repeat with LBU -> rdata_o 0x80.
- LW at 0x2004, resp 0x8000_0001_0000_0000 -> 0xFFFFFFFF80000001. Repeat with LWU -> 0x0000000080000001.
- Backpressure: dmem_req_ready low for 4 cycles -> dmem_req_valid held with stable addr/data, stall_o stays 1, no done_o; a spurious resp_valid during REQ is ignored.
- rstn low while in WAIT -> next cycle state IDLE, dmem_req_valid 0, stall_o 0; a following resp_valid produces no done_o.
